// File: rtl/evenz_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : evenz_drv_pkg
// Purpose  : Shared types and constants for the dual-rail even-zeroes driver.
//            FSM state encoding plus the dual-rail codes, written {bit1,bit0}.
// Revision : 1.0 - initial release
// ============================================================================
package evenz_drv_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACK  = 3'd2,
    RTZ       = 3'd3,
    WAIT_NULL = 3'd4,
    DONE      = 3'd5,
    ABORT     = 3'd6
  } state_t;

  localparam logic [1:0] RAIL_NULL = 2'b00;
  localparam logic [1:0] RAIL_D0   = 2'b01;
  localparam logic [1:0] RAIL_D1   = 2'b10;
  localparam logic [1:0] RAIL_ILL  = 2'b11;

  // Dual-rail encoding of one data bit: a 1 raises bit1, a 0 raises bit0.
  function automatic logic [1:0] rail_code(input logic b);
    return b ? RAIL_D1 : RAIL_D0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dr_sync.sv
`default_nettype none
// ============================================================================
// Module   : dr_sync
// Purpose  : STAGES-deep flop synchroniser for a 2-bit dual-rail bundle.
// Ports    : clk, rst_n (async, active low), din[1:0] async in,
//            dout[1:0] synchronised out.
// Revision : 1.0 - initial release
// ============================================================================
module dr_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] din,
  output logic [1:0] dout
);

  logic [1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= 2'b00;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign dout = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/evenzeroes_dr_driver.sv
`default_nettype none
// ============================================================================
// Module   : evenzeroes_dr_driver
// Purpose  : Serialises a WIDTH-bit word LSB-first onto dual-rail bit0/bit1
//            with a four-phase return-to-zero handshake; completion comes from
//            the parity0/parity1 rails of the even-zeroes block. The last rail
//            seen is reported as the word result.
// Ports    : clk, rst_n (async active low)
//            in_valid/in_ready/in_data  - word input (valid/ready)
//            bit0/bit1                  - registered dual-rail data out
//            parity0/parity1            - async completion rails in
//            out_valid/out_even/out_err - one-cycle word result
//            chk_mismatch               - sticky model disagreement flag
//                                         (only with EVENZ_DRV_CHECK_EN)
// Config   : `define EVENZ_DRV_CHECK_EN adds a cumulative zero-parity
//            reference model and the chk_mismatch port.
// Revision : 1.0 - initial release
// ============================================================================
module evenzeroes_dr_driver
  import evenz_drv_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             bit0,
  output logic             bit1,
  input  logic             parity0,
  input  logic             parity1,
  output logic             out_valid,
  output logic             out_even,
  output logic             out_err
`ifdef EVENZ_DRV_CHECK_EN
  ,
  output logic             chk_mismatch
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] TMO      = CW'(TIMEOUT_CYC);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shnext;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    tcnt;
  logic             last;
  logic             err;
  logic             chk_word;
  logic [1:0]       par;        // synchronised {parity1,parity0}

  logic             accept, timeout, ack_seen, ack_ill, null_seen, send_bit;
  logic [1:0]       rails_d;
  logic             ready_d, valid_d, even_d, err_d;

  dr_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({parity1, parity0}),
    .dout (par)
  );

  assign accept    = in_valid && in_ready;
  assign timeout   = (tcnt == TMO);
  assign ack_ill   = (par == RAIL_ILL);
  assign ack_seen  = (par != RAIL_NULL);
  assign null_seen = (par == RAIL_NULL);
  assign shnext    = shreg >> 1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = SEND;
      SEND:      next_state = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_ill)       next_state = ABORT;
        else if (ack_seen) next_state = RTZ;
        else if (timeout)  next_state = ABORT;
      end
      RTZ:       next_state = WAIT_NULL;
      WAIT_NULL: begin
        if (null_seen)    next_state = (idx == LAST_IDX) ? DONE : SEND;
        else if (timeout) next_state = ABORT;
      end
      // Abort reports through DONE so in_ready stays low during out_valid.
      DONE:      next_state = IDLE;
      ABORT:     if (null_seen || timeout) next_state = DONE;
      default:   next_state = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on next_state
  // so rails are already up during the SEND cycle.
  always_comb begin
    send_bit = (state == IDLE) ? in_data[0] : shnext[0];
    case (next_state)
      SEND:     rails_d = rail_code(send_bit);
      WAIT_ACK: rails_d = {bit1, bit0};
      default:  rails_d = RAIL_NULL;
    endcase
    ready_d = (next_state == IDLE);
    valid_d = (next_state == DONE);
    even_d  = valid_d && last && !err;
    err_d   = valid_d && (err || chk_word);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit0      <= 1'b0;
      bit1      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_even  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      {bit1, bit0} <= rails_d;
      in_ready     <= ready_d;
      out_valid    <= valid_d;
      out_even     <= even_d;
      out_err      <= err_d;
    end
  end

  // Word datapath and wait-state timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
      tcnt  <= '0;
      last  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        shreg <= in_data;
        idx   <= '0;
        err   <= 1'b0;
      end else if (state == WAIT_NULL && null_seen && idx != LAST_IDX) begin
        shreg <= shnext;
        idx   <= idx + IW'(1);
      end

      if (state == WAIT_ACK && ack_seen && !ack_ill) last <= par[1];
      if (next_state == ABORT && state != ABORT)     err  <= 1'b1;

      // Timer restarts on every state change and saturates while waiting.
      if (next_state != state) tcnt <= '0;
      else if ((state == WAIT_ACK || state == WAIT_NULL || state == ABORT) && !timeout)
        tcnt <= tcnt + CW'(1);
    end
  end

`ifdef EVENZ_DRV_CHECK_EN
  // zpar = 1 when an odd number of zeros has been sent since reset, which
  // means the block should answer on parity0.
  logic zpar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zpar         <= 1'b0;
      chk_word     <= 1'b0;
      chk_mismatch <= 1'b0;
    end else begin
      if (state == SEND) zpar <= zpar ^ ~shreg[0];
      if (accept) chk_word <= 1'b0;
      else if (state == WAIT_ACK && ack_seen && !ack_ill && par[0] != zpar) begin
        chk_word     <= 1'b1;
        chk_mismatch <= 1'b1;
      end
    end
  end
`else
  assign chk_word = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_evenzeroes_dr_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_evenzeroes_dr_driver
// Purpose  : Self-checking bench for evenzeroes_dr_driver with a behavioural
//            even-zeroes responder (programmable delay and fault modes) and a
//            scoreboard of expected {out_even,out_err} per word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_evenzeroes_dr_driver;

  localparam int WIDTH = 8;
  localparam int TMO   = 1023;

  localparam int M_NORMAL = 0;
  localparam int M_NOACK  = 1;
  localparam int M_ILL    = 2;
  localparam int M_INV    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, bit0, bit1, out_valid, out_even, out_err;
  logic             parity0 = 1'b0;
  logic             parity1 = 1'b0;
`ifdef EVENZ_DRV_CHECK_EN
  logic             chk_mismatch;
`endif

  evenzeroes_dr_driver #(.WIDTH(WIDTH), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .bit0        (bit0),
    .bit1        (bit1),
    .parity0     (parity0),
    .parity1     (parity1),
    .out_valid   (out_valid),
    .out_even    (out_even),
    .out_err     (out_err)
`ifdef EVENZ_DRV_CHECK_EN
    ,
    .chk_mismatch(chk_mismatch)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  logic [1:0] exp_q [$];     // {even, err}
  logic       exp_odd = 1'b0;

  // responder controls / observations
  int         mode = M_NORMAL;
  int         fault_phase = 0;
  int         resp_delay = 0;
  int         phase_cnt = 0;
  logic       odd = 1'b0;
  logic [1:0] rail_log [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural even-zeroes block: keeps cumulative zero parity until reset.
  always @(bit0 or bit1 or rst_n) begin : responder
    logic [1:0] code;
    code = {bit1, bit0};
    if (!rst_n) begin
      odd = 1'b0; phase_cnt = 0; parity0 = 1'b0; parity1 = 1'b0;
    end else begin
      if (resp_delay > 0) #(resp_delay);
      if (code == 2'b00) begin
        parity0 = 1'b0; parity1 = 1'b0;
      end else begin
        phase_cnt++;
        rail_log.push_back(code);
        odd = odd ^ code[0];
        if (mode == M_NOACK) begin
          parity0 = 1'b0; parity1 = 1'b0;
        end else if (mode == M_ILL && phase_cnt == fault_phase) begin
          parity0 = 1'b1; parity1 = 1'b1;
        end else if (mode == M_INV && phase_cnt == fault_phase) begin
          parity0 = ~odd; parity1 = odd;
        end else begin
          parity0 = odd; parity1 = ~odd;
        end
      end
    end
  end

  // Scoreboard monitor and rail-overlap watch
  always @(negedge clk) begin
    check_eq("rail_overlap", {31'd0, bit0 & bit1}, 32'd0);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check_eq("out_even", {31'd0, out_even}, {31'd0, e[1]});
        check_eq("out_err",  {31'd0, out_err},  {31'd0, e[0]});
      end
      done_cnt++;
    end
  end

  task automatic sys_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_odd = 1'b0;
    mode = M_NORMAL;
  endtask

  // Offer a word; optionally push its expected result to the scoreboard.
  task automatic send(input logic [WIDTH-1:0] d, input bit push, input bit exp_err, input bit model);
    int n;
    logic [3:0] zeros;
    logic       ev;
    zeros = 4'(WIDTH - $countones(d));
    if (model) exp_odd = exp_odd ^ zeros[0];
    ev = exp_err ? 1'b0 : ~exp_odd;
    if (push) exp_q.push_back({ev, exp_err});
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt < target) check_eq("wait_done_timeout", done_cnt, target);
  endtask

  // Plain word: expected result from the bench's cumulative model.
  task automatic word(input logic [WIDTH-1:0] d);
    send(d, 1'b1, 1'b0, 1'b1);
    wait_done(done_cnt + 1, 400);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check_eq("rst_rails",     {30'd0, bit1, bit0}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_even",  {31'd0, out_even},  32'd0);
    check_eq("rst_out_err",   {31'd0, out_err},   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: all ones -> eight bit1 phases, even
    rail_log.delete();
    word(8'hFF);
    check_eq("ff_phase_count", rail_log.size(), 8);
    for (int i = 0; i < rail_log.size(); i++) check_eq("ff_rail_code", {30'd0, rail_log[i]}, 32'd2);

    // 2: cumulative zero count across words
    word(8'h01);
    rail_log.delete();
    word(8'hFE);
    check_eq("fe_first_rail", {30'd0, rail_log[0]}, 32'd1);

    // slow responder
    resp_delay = 23;
    word(8'h07);
    word(8'h5A);
    resp_delay = 0;

    // 3: responder never acks -> timeout abort
    mode = M_NOACK;
    send(8'hA5, 1'b1, 1'b1, 1'b0);
    wait_done(done_cnt + 1, TMO + 200);
    check_eq("tmo_rails_zero",     {30'd0, bit1, bit0}, 32'd0);
    check_eq("tmo_ready_in_valid", {31'd0, in_ready},   32'd0);
    @(negedge clk);
    check_eq("tmo_ready_after",    {31'd0, in_ready},   32'd1);

    // 4: illegal code on bit 3
    sys_reset();
    mode = M_ILL;
    fault_phase = 4;
    send(8'h00, 1'b1, 1'b1, 1'b0);
    wait_done(done_cnt + 1, 400);
    check_eq("ill_rails_zero", {30'd0, bit1, bit0}, 32'd0);

    // 5: reset during WAIT_ACK of bit 5
    sys_reset();
    base = done_cnt;
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (phase_cnt < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reached_bit5", phase_cnt, 6);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rails", {30'd0, bit1, bit0}, 32'd0);
    check_eq("midrst_ready", {31'd0, in_ready},   32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    exp_odd = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("midrst_no_valid", done_cnt, base);
    rail_log.delete();
    word(8'hFE);
    check_eq("midrst_first_rail", {30'd0, rail_log[0]}, 32'd1);
    check_eq("midrst_phases",     rail_log.size(), 8);

`ifdef EVENZ_DRV_CHECK_EN
    // 6: inverted answer on bit 2 trips the reference model
    sys_reset();
    mode = M_INV;
    fault_phase = phase_cnt + 3;
    send(8'hFF, 1'b1, 1'b0, 1'b1);
    exp_q[exp_q.size()-1] = 2'b11;   // even result, error flagged by model
    wait_done(done_cnt + 1, 400);
    check_eq("chk_mismatch_set", {31'd0, chk_mismatch}, 32'd1);
    mode = M_NORMAL;
    word(8'hFF);
    check_eq("chk_mismatch_sticky", {31'd0, chk_mismatch}, 32'd1);
`endif

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
